// File: rtl/program_loader.sv
// program_loader: boot-time loader that receives a framed byte stream
// (LEN, N x {hi, lo}, CSUM) over valid/ready, writes 16-bit instructions
// into instruction memory, verifies the checksum, then pulses the processor
// restart and holds controller_enable high until the next load request.
//
// Ports:
//   i_clk            system clock, all state changes on rising edge
//   i_rst            synchronous active-high reset
//   i_load_start     request a new load (honoured in IDLE, RUN and ERR)
//   i_in_valid       byte source has i_in_data valid
//   i_in_data        stream byte
//   o_in_ready       loader accepts a byte this cycle
//   o_imem_we        instruction memory write strobe
//   o_imem_addr      instruction memory write address (held when not writing)
//   o_imem_wdata     instruction memory write data (held when not writing)
//   o_proc_restart   one-cycle restart pulse to the processor controller
//   o_proc_enable    processor controller_enable
//   o_busy           a frame is in progress (LEN..RESTART)
//   o_loaded_count   instructions written in the current or last frame
//   o_error          high while in ERR
//   o_err_code       0 none, 1 bad length, 2 checksum mismatch
module program_loader #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_start,
    input  logic               i_in_valid,
    input  logic [7:0]         i_in_data,
    output logic               o_in_ready,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_imem_wdata,
    output logic               o_proc_restart,
    output logic               o_proc_enable,
    output logic               o_busy,
    output logic [ADDR_W:0]    o_loaded_count,
    output logic               o_error,
    output logic [1:0]         o_err_code
);

    // count needs one extra bit so a full DEPTH-instruction frame is representable
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_RESTART,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state,        w_state;
    logic [CNT_W-1:0]    r_len,          w_len;
    logic [CNT_W-1:0]    r_count,        w_count;
    logic [7:0]          r_sum,          w_sum;
    logic [7:0]          r_hi,           w_hi;
    logic [1:0]          r_err_code,     w_err_code;
    logic [ADDR_W-1:0]   r_imem_addr,    w_imem_addr;
    logic [INSTR_W-1:0]  r_imem_wdata,   w_imem_wdata;
    logic                r_imem_we,      w_imem_we;
    logic                r_in_ready,     w_in_ready;
    logic                r_proc_restart, w_proc_restart;
    logic                r_proc_enable,  w_proc_enable;
    logic                r_busy,         w_busy;
    logic                r_error,        w_error;

    logic                w_accept;
    logic [CNT_W-1:0]    w_count_inc;

    assign w_accept    = i_in_valid && r_in_ready;
    assign w_count_inc = r_count + CNT_W'(1);

    // State and registered-output update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_count        <= '0;
            r_sum          <= '0;
            r_hi           <= '0;
            r_err_code     <= ERR_NONE;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_imem_we      <= 1'b0;
            r_in_ready     <= 1'b0;
            r_proc_restart <= 1'b0;
            r_proc_enable  <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_len          <= w_len;
            r_count        <= w_count;
            r_sum          <= w_sum;
            r_hi           <= w_hi;
            r_err_code     <= w_err_code;
            r_imem_addr    <= w_imem_addr;
            r_imem_wdata   <= w_imem_wdata;
            r_imem_we      <= w_imem_we;
            r_in_ready     <= w_in_ready;
            r_proc_restart <= w_proc_restart;
            r_proc_enable  <= w_proc_enable;
            r_busy         <= w_busy;
            r_error        <= w_error;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        w_state      = r_state;
        w_len        = r_len;
        w_count      = r_count;
        w_sum        = r_sum;
        w_hi         = r_hi;
        w_err_code   = r_err_code;
        w_imem_addr  = r_imem_addr;
        w_imem_wdata = r_imem_wdata;
        w_imem_we    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_load_start) begin
                    w_state = S_LEN;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    if ((i_in_data == 8'd0) || (32'(i_in_data) > DEPTH)) begin
                        w_state    = S_ERR;
                        w_err_code = ERR_LEN;
                    end else begin
                        w_len   = CNT_W'(i_in_data);
                        w_sum   = i_in_data;
                        w_count = '0;
                        w_state = S_HI;
                    end
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_hi    = i_in_data;
                    w_sum   = r_sum + i_in_data;
                    w_state = S_LO;
                end
            end
            S_LO: begin
                if (w_accept) begin
                    w_imem_we    = 1'b1;
                    w_imem_addr  = r_count[ADDR_W-1:0];
                    w_imem_wdata = INSTR_W'({r_hi, i_in_data});
                    w_sum        = r_sum + i_in_data;
                    w_count      = w_count_inc;
                    w_state      = (w_count_inc == r_len) ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (i_in_data == r_sum) begin
                        w_state = S_RESTART;
                    end else begin
                        w_state    = S_ERR;
                        w_err_code = ERR_CSUM;
                    end
                end
            end
            S_RESTART: begin
                w_state = S_RUN;
            end
            S_RUN: begin
                if (i_load_start) begin
                    w_state = S_LEN;
                end
            end
            S_ERR: begin
                if (i_load_start) begin
                    w_err_code = ERR_NONE;
                    w_state    = S_LEN;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it once registered
        w_in_ready     = (w_state == S_LEN) || (w_state == S_HI) ||
                         (w_state == S_LO)  || (w_state == S_CSUM);
        w_busy         = w_in_ready || (w_state == S_RESTART);
        w_proc_restart = (w_state == S_RESTART);
        w_proc_enable  = (w_state == S_RUN);
        w_error        = (w_state == S_ERR);
    end

    assign o_in_ready     = r_in_ready;
    assign o_imem_we      = r_imem_we;
    assign o_imem_addr    = r_imem_addr;
    assign o_imem_wdata   = r_imem_wdata;
    assign o_proc_restart = r_proc_restart;
    assign o_proc_enable  = r_proc_enable;
    assign o_busy         = r_busy;
    assign o_loaded_count = r_count;
    assign o_error        = r_error;
    assign o_err_code     = r_err_code;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader. Frames are
// described in a vector table; expected memory writes go into a scoreboard
// queue and are compared by a monitor as the DUT issues them.
module tb_program_loader;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned INSTR_W = 16;
    localparam int          NV      = 8;

    logic                clk = 1'b0;
    logic                i_rst;
    logic                i_load_start;
    logic                i_in_valid;
    logic [7:0]          i_in_data;
    logic                o_in_ready;
    logic                o_imem_we;
    logic [ADDR_W-1:0]   o_imem_addr;
    logic [INSTR_W-1:0]  o_imem_wdata;
    logic                o_proc_restart;
    logic                o_proc_enable;
    logic                o_busy;
    logic [ADDR_W:0]     o_loaded_count;
    logic                o_error;
    logic [1:0]          o_err_code;

    program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_load_start   (i_load_start),
        .i_in_valid     (i_in_valid),
        .i_in_data      (i_in_data),
        .o_in_ready     (o_in_ready),
        .o_imem_we      (o_imem_we),
        .o_imem_addr    (o_imem_addr),
        .o_imem_wdata   (o_imem_wdata),
        .o_proc_restart (o_proc_restart),
        .o_proc_enable  (o_proc_enable),
        .o_busy         (o_busy),
        .o_loaded_count (o_loaded_count),
        .o_error        (o_error),
        .o_err_code     (o_err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        bit          bad_csum;
        bit          gap;
        int unsigned seed;
        logic [1:0]  exp_err;
        bit          exp_run;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } wr_t;

    vec_t vecs [NV];
    wr_t  exp_q [$];
    int   checks    = 0;
    int   errors    = 0;
    int   restarts  = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] instr_of(input int unsigned seed, input int i);
        if (seed == 0) begin
            case (i)
                0:       return 16'h1234;
                1:       return 16'hABCD;
                default: return 16'h0001;
            endcase
        end
        return 16'((i * 32'h0123 + seed * 32'h0101) ^ 32'hA5C3);
    endfunction

    // Monitor: pop expected writes, check address hold and restart width
    initial begin : monitor
        logic              rst_seen;
        logic              prev_restart;
        logic [ADDR_W-1:0] last_addr;
        wr_t               e;
        prev_restart = 1'b0;
        last_addr    = '0;
        forever begin
            @(posedge clk);
            rst_seen = i_rst;
            #1;
            if (rst_seen) begin
                last_addr    = '0;
                prev_restart = 1'b0;
            end else begin
                if (o_imem_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", o_imem_addr, o_imem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("imem_addr", 32'(o_imem_addr), 32'(e.addr));
                        check("imem_wdata", 32'(o_imem_wdata), 32'(e.data));
                        last_addr = e.addr;
                    end
                end else begin
                    check("imem_addr_hold", 32'(o_imem_addr), 32'(last_addr));
                end
                if (o_proc_restart) begin
                    restarts++;
                    check("restart_width", 32'(prev_restart), 32'd0);
                end
                prev_restart = o_proc_restart;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int guard;
        guard = 0;
        i_in_data  = b;
        i_in_valid = 1'b1;
        while (!o_in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        i_load_start = 1'b1;
        @(posedge clk); #1;
        i_load_start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_in_ready, o_imem_we, o_proc_restart, o_proc_enable, o_busy,
                     o_error, o_err_code, o_loaded_count, o_imem_addr, 16'h0}, 32'd0);
        check({name, "_wdata"}, 32'(o_imem_wdata), 32'd0);
    endtask

    initial begin : main
        logic [15:0] w;
        logic [7:0]  sum;
        logic [7:0]  csum;
        bit          len_ok;
        int          r0;

        //            len bad gap seed   err  run
        vecs[0] = '{   3, 0, 0, 0,     2'd0, 1};
        vecs[1] = '{   3, 1, 0, 0,     2'd2, 0};
        vecs[2] = '{   0, 0, 0, 0,     2'd1, 0};
        vecs[3] = '{  65, 0, 0, 0,     2'd1, 0};
        vecs[4] = '{  64, 0, 0, 32'h5A, 2'd0, 1};
        vecs[5] = '{   2, 0, 1, 32'h77, 2'd0, 1};
        vecs[6] = '{   5, 0, 0, 32'h3C, 2'd0, 1};
        vecs[7] = '{   1, 1, 1, 32'hFF, 2'd2, 0};

        i_rst        = 1'b1;
        i_load_start = 1'b0;
        i_in_valid   = 1'b0;
        i_in_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        i_rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(o_in_ready), 32'd0);

        // Reset mid-frame, with a load_start during LO that must be ignored
        pulse_start();
        check("mid_busy_after_start", 32'(o_busy), 32'd1);
        exp_q.push_back('{6'd0, 16'h1234});
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        i_load_start = 1'b1;
        @(posedge clk); #1;
        i_load_start = 1'b0;
        check("ignored_start_ready", 32'(o_in_ready), 32'd1);
        send_byte(8'h34, 1'b0);
        check("mid_count", 32'(o_loaded_count), 32'd1);
        i_in_data  = 8'hAB;
        i_in_valid = 1'b1;
        i_rst      = 1'b1;
        @(posedge clk); #1;
        i_rst      = 1'b0;
        i_in_valid = 1'b0;
        check_all_zero("mid_reset_outputs");
        check("mid_reset_queue", 32'(exp_q.size()), 32'd0);
        model_cnt = 0;
        @(posedge clk); #1;
        check("mid_reset_idle_ready", 32'(o_in_ready), 32'd0);

        for (int v = 0; v < NV; v++) begin
            len_ok = (vecs[v].len >= 1) && (vecs[v].len <= int'(DEPTH));
            r0     = restarts;
            pulse_start();
            check("start_enable", 32'(o_proc_enable), 32'd0);
            check("start_busy", 32'(o_busy), 32'd1);
            check("start_error", {30'd0, o_error, 1'b0} | 32'(o_err_code), 32'd0);
            sum = 8'(vecs[v].len);
            send_byte(8'(vecs[v].len), vecs[v].gap);
            if (len_ok) begin
                for (int i = 0; i < vecs[v].len; i++) begin
                    w = instr_of(vecs[v].seed, i);
                    exp_q.push_back('{6'(i), w});
                    sum = sum + w[15:8];
                    sum = sum + w[7:0];
                end
                for (int i = 0; i < vecs[v].len; i++) begin
                    w = instr_of(vecs[v].seed, i);
                    send_byte(w[15:8], vecs[v].gap);
                    send_byte(w[7:0], vecs[v].gap);
                end
                model_cnt = vecs[v].len;
                csum = vecs[v].bad_csum ? 8'(sum + 8'd1) : sum;
                send_byte(csum, 1'b0);
                check("restart_latency", 32'(o_proc_restart), 32'(!vecs[v].bad_csum));
                check("enable_not_yet", 32'(o_proc_enable), 32'd0);
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
            check("final_error", 32'(o_error), 32'(vecs[v].exp_err != 2'd0));
            check("final_err_code", 32'(o_err_code), 32'(vecs[v].exp_err));
            check("final_enable", 32'(o_proc_enable), 32'(vecs[v].exp_run));
            check("final_count", 32'(o_loaded_count), 32'(model_cnt));
            check("final_busy", 32'(o_busy), 32'd0);
            check("final_ready", 32'(o_in_ready), 32'd0);
            check("final_restart_low", 32'(o_proc_restart), 32'd0);
            check("restart_count", 32'(restarts - r0), 32'(vecs[v].exp_run));
            check("writes_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
